// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: releases NUM_DOMAINS reset domains in order once power is good.
// Optional macro POR_SEQ_REVERSE_ASSERT_EN makes a soft reset in RUN re-assert the domains in reverse order.
module por_reset_sequencer #(
   parameter int NUM_DOMAINS = 4,
   parameter int GAP_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   por_ok,
   input  logic                   soft_rst_req,
   input  logic [GAP_W-1:0]       gap_cycles,
   output logic [NUM_DOMAINS-1:0] dom_rst,
   output logic                   busy,
   output logic                   ready
);

   localparam int IDX_W = $clog2(NUM_DOMAINS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

`ifdef POR_SEQ_REVERSE_ASSERT_EN
   typedef enum logic [1:0] {HOLD, RELEASE, RUN, ASSERT} state_t;
`else
   typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
`endif

   state_t                 state, state_n;
   logic [IDX_W-1:0]       idx, idx_n;
   logic [GAP_W-1:0]       cnt, cnt_n;
   logic [NUM_DOMAINS-1:0] dom_n;
   logic [1:0]             sync_q;
   logic                   por_ok_s;

   // por_ok comes straight from an analog detector, so it is synchronized before any decision uses it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], por_ok};
   end

   assign por_ok_s = sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HOLD;
         idx     <= '0;
         cnt     <= '0;
         dom_rst <= '1;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         cnt     <= cnt_n;
         dom_rst <= dom_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      dom_n   = dom_rst;
      case (state)
         HOLD: begin
            dom_n = '1;
            if (por_ok_s) begin
               state_n = RELEASE;
               idx_n   = '0;
               cnt_n   = gap_cycles;
            end
         end
         RELEASE: begin
            if (soft_rst_req) begin
               state_n = HOLD;
               dom_n   = '1;
            end else if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else begin
               dom_n[idx] = 1'b0;
               if (idx == LAST_IDX) begin
                  state_n = RUN;
               end else begin
                  idx_n = idx + 1'b1;
                  cnt_n = gap_cycles;
               end
            end
         end
         RUN: begin
            if (soft_rst_req) begin
`ifdef POR_SEQ_REVERSE_ASSERT_EN
               state_n = ASSERT;
               idx_n   = LAST_IDX;
               cnt_n   = gap_cycles;
`else
               state_n = HOLD;
               dom_n   = '1;
`endif
            end
         end
`ifdef POR_SEQ_REVERSE_ASSERT_EN
         ASSERT: begin
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else begin
               dom_n[idx] = 1'b1;
               if (idx == '0) begin
                  state_n = HOLD;
               end else begin
                  idx_n = idx - 1'b1;
                  cnt_n = gap_cycles;
               end
            end
         end
`endif
         default: begin
            state_n = HOLD;
            dom_n   = '1;
         end
      endcase
      // Losing power overrides any step or soft request taken on the same cycle
      if ((state != HOLD) && !por_ok_s) begin
         state_n = HOLD;
         dom_n   = '1;
         idx_n   = '0;
         cnt_n   = '0;
      end
   end

`ifdef POR_SEQ_REVERSE_ASSERT_EN
   assign busy = (state == RELEASE) || (state == ASSERT);
`else
   assign busy = (state == RELEASE);
`endif
   assign ready = (state == RUN) && (dom_rst == '0);

endmodule
